// File: rtl/nibble_serial_adder_pkg.sv
// Shared constants and state encoding for the nibble-serial adder.
package nibble_serial_adder_pkg;

    // Width of the shared ripple-carry adder slice.
    localparam int unsigned NIBBLE_W = 4;

    // Controller state encoding; 2'd3 is unused and recovers to IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2,
        ST_BAD  = 2'd3
    } state_e;

endpackage

// File: rtl/Ripple_Carry_Adder.sv
// Four-bit ripple-carry adder shared by the serial controller.
module Ripple_Carry_Adder
    import nibble_serial_adder_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] carry;

    assign carry[0] = cin;

    // One full adder per bit, carry chained from bit 0 upward.
    for (genvar i = 0; i < int'(NIBBLE_W); i++) begin : g_fa
        assign sum[i]       = a[i] ^ b[i] ^ carry[i];
        assign carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end

    assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// WIDTH-bit adder that processes one nibble per cycle through a single
// 4-bit ripple-carry adder, with valid/ready handshakes on both sides.
// WIDTH must be a multiple of 4 and at least 4.
module nibble_serial_adder
    import nibble_serial_adder_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
    localparam int unsigned IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_sh_q, a_sh_d;
    logic [WIDTH-1:0]   b_sh_q, b_sh_d;
    logic [WIDTH-1:0]   sum_sh_q, sum_sh_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               cout_q, cout_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0]       rca_sum;
    logic                      rca_cout;
    logic [WIDTH+NIBBLE_W-1:0] sum_cat;
    logic [WIDTH-1:0]          sum_sh_nxt;
    logic                      last_nib;

    // Shared nibble adder: always looks at the low nibble of the shift registers.
    Ripple_Carry_Adder u_rca (
        .a    (a_sh_q[NIBBLE_W-1:0]),
        .b    (b_sh_q[NIBBLE_W-1:0]),
        .cin  (carry_q),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    // New result nibble enters at the top; after NIBBLES shifts the word is aligned.
    assign sum_cat    = {rca_sum, sum_sh_q};
    assign sum_sh_nxt = sum_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
    assign last_nib   = (idx_q == IDX_W'(NIBBLES - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_RUN;
            ST_RUN:  if (last_nib)  state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the upcoming state so they register cleanly.
    always_comb begin
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // Datapath: capture on accept, shift one nibble per RUN cycle, load result on the last.
    always_comb begin
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        idx_d    = idx_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    carry_d = cin;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                sum_sh_d = sum_sh_nxt;
                carry_d  = rca_cout;
                a_sh_d   = a_sh_q >> NIBBLE_W;
                b_sh_d   = b_sh_q >> NIBBLE_W;
                idx_d    = idx_q + IDX_W'(1);
                if (last_nib) begin
                    sum_d  = sum_sh_nxt;
                    cout_d = rca_cout;
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            sum_sh_q    <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            sum_sh_q    <= sum_sh_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed bench for nibble_serial_adder: a 16-bit instance for the main
// scenarios and an 8-bit instance for a broad operand sweep.
module tb_nibble_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [15:0] a, b, sum;

    logic        in_valid8, in_ready8, out_valid8, out_ready8, cin8, cout8;
    logic [7:0]  a8, b8, sum8;

    int checks = 0;
    int errors = 0;

    nibble_serial_adder #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    nibble_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .sum(sum8), .cout(cout8)
    );

    // Present one operation to the 16-bit instance; returns at accept edge + 1.
    task automatic issue16(input logic [15:0] ta, input logic [15:0] tb, input logic tc);
        int g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL issue16_timeout: in_ready=%b required 1", in_ready);
        end
        a = ta; b = tb; cin = tc; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Count edges until out_valid on the 16-bit instance (bounded).
    task automatic wait16(output int n);
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    // Take the result with a single out_ready edge.
    task automatic consume16();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic issue8(input logic [7:0] ta, input logic [7:0] tb, input logic tc);
        int g = 0;
        @(negedge clk);
        while (!in_ready8 && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready8) begin
            checks++; errors++;
            $display("FAIL issue8_timeout: in_ready=%b required 1", in_ready8);
        end
        a8 = ta; b8 = tb; cin8 = tc; in_valid8 = 1'b1;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
    endtask

    task automatic wait8(output int n);
        n = 0;
        while (!out_valid8 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_handshake: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b0) begin
            errors++;
            $display("FAIL reset_result: sum=%h cout=%b required 0000/0", sum, cout);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_zero_latency();
        int n;
        issue16(16'h0000, 16'h0000, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL run_handshake: in_ready=%b out_valid=%b required 0/0", in_ready, out_valid);
        end
        wait16(n);
        checks++;
        if (n !== 4) begin
            errors++;
            $display("FAIL latency16: edges=%0d required 4", n);
        end
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b0 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL zero_sum: sum=%h cout=%b in_ready=%b required 0000/0/0", sum, cout, in_ready);
        end
        consume16();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL zero_release: in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
        end
    endtask

    task automatic test_carry();
        int n;
        issue16(16'hFFFF, 16'h0001, 1'b0);
        wait16(n);
        checks++;
        if (sum !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL carry_ripple: sum=%h cout=%b required 0000/1", sum, cout);
        end
        consume16();
        issue16(16'h1234, 16'h4321, 1'b1);
        wait16(n);
        checks++;
        if (sum !== 16'h5556 || cout !== 1'b0) begin
            errors++;
            $display("FAIL carry_cin: sum=%h cout=%b required 5556/0", sum, cout);
        end
        consume16();
    endtask

    task automatic test_backpressure();
        int n;
        issue16(16'h8000, 16'h8000, 1'b0);
        wait16(n);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== 16'h0000 || cout !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: ov=%b ir=%b sum=%h cout=%b required 1/0/0000/1",
                         i, out_valid, in_ready, sum, cout);
            end
        end
        consume16();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000 || cout !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: ov=%b ir=%b sum=%h cout=%b required 0/1/0000/1",
                     out_valid, in_ready, sum, cout);
        end
    endtask

    task automatic test_reset_abort();
        int n;
        int seen = 0;
        issue16(16'hAAAA, 16'h5555, 1'b1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || sum !== 16'h0000) begin
            errors++;
            $display("FAIL abort_reset: ov=%b ir=%b sum=%h required 0/1/0000", out_valid, in_ready, sum);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL abort_no_valid: out_valid cycles=%0d required 0", seen);
        end
        issue16(16'h00FF, 16'h0001, 1'b0);
        wait16(n);
        checks++;
        if (sum !== 16'h0100 || cout !== 1'b0 || n !== 4) begin
            errors++;
            $display("FAIL abort_next_op: sum=%h cout=%b edges=%0d required 0100/0/4", sum, cout, n);
        end
        consume16();
    endtask

    task automatic test_in_valid_ignored();
        int n;
        issue16(16'h1111, 16'h2222, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = 16'hFFFF ^ 16'(i); b = 16'hFFFF; cin = 1'b1;
            in_valid = (i % 2 == 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        wait16(n);
        checks++;
        if (sum !== 16'h3333 || cout !== 1'b0) begin
            errors++;
            $display("FAIL ignore_in_valid: sum=%h cout=%b required 3333/0", sum, cout);
        end
        consume16();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL ignore_no_phantom: ov=%b ir=%b required 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_width8_sweep();
        logic [7:0] bv [6];
        logic [7:0] ta, tb;
        logic [8:0] exp;
        int n;
        int sweep_err = 0;
        int first = 1;
        for (int ai = 0; ai < 256; ai += 5) begin
            ta = 8'(ai);
            bv[0] = 8'h00; bv[1] = 8'h01; bv[2] = 8'h7F;
            bv[3] = 8'h80; bv[4] = 8'hFF; bv[5] = ta ^ 8'h5A;
            for (int bi = 0; bi < 6; bi++) begin
                for (int c = 0; c < 2; c++) begin
                    tb  = bv[bi];
                    exp = {1'b0, ta} + {1'b0, tb} + 9'(c);
                    issue8(ta, tb, 1'(c));
                    wait8(n);
                    if (first == 1) begin
                        first = 0;
                        checks++;
                        if (n !== 2) begin
                            errors++;
                            $display("FAIL latency8: edges=%0d required 2", n);
                        end
                    end
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                    checks++;
                    if ({cout8, sum8} !== exp || out_valid8 !== 1'b1) begin
                        errors++;
                        sweep_err++;
                        $display("FAIL sweep8 %h+%h+%0d: got %h ov=%b required %h/1",
                                 ta, tb, c, {cout8, sum8}, out_valid8, exp);
                    end
                    @(negedge clk);
                    out_ready8 = 1'b1;
                    @(posedge clk); #1;
                    out_ready8 = 1'b0;
                end
            end
        end
        if (sweep_err == 0) $display("width8 sweep complete");
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid8 = 1'b0; out_ready8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
        test_reset();
        test_zero_latency();
        test_carry();
        test_backpressure();
        test_reset_abort();
        test_in_valid_ignored();
        test_width8_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
